// File: rtl/tank_countdown_timer.sv
// Millisecond countdown timer for the tank control FSM's timeout windows.
// Optional feature: define TIMER_AUTORELOAD_EN to restart the window after each expiry.
module tank_countdown_timer #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int PRESET      = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_reset,
  input  logic        timer_enable,
  output logic [15:0] timer_value,
  output logic        tick,
  output logic        expired,
  output logic        running
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
  localparam logic [15:0]   PRESET_V  = 16'(PRESET);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic          enable_d;
  logic          enable_rise;

  // Handshake: timer_reset and timer_enable are plain levels sampled every
  // clock; there is no valid/ready pairing, the FSM simply holds them.
  assign enable_rise = timer_enable & ~enable_d;
  assign running     = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pcnt        <= '0;
      enable_d    <= 1'b0;
      timer_value <= PRESET_V;
      tick        <= 1'b0;
      expired     <= 1'b0;
    end else begin
      enable_d <= timer_enable;
      tick     <= 1'b0;
      expired  <= 1'b0;
      if (timer_reset) begin
        state       <= IDLE;
        pcnt        <= '0;
        timer_value <= PRESET_V;
      end else if (enable_rise) begin
        // Every fresh enable starts a full window, even from a stale zero.
        state       <= RUN;
        pcnt        <= '0;
        timer_value <= PRESET_V;
      end else begin
        case (state)
          IDLE: ;
          RUN: begin
            if (!timer_enable) begin
              state <= IDLE;
`ifdef TIMER_AUTORELOAD_EN
            end else if (timer_value == 16'd0) begin
              // Prescaler keeps running so successive windows stay PRESET*DIV apart.
              timer_value <= PRESET_V;
              pcnt        <= pcnt + 1'b1;
`endif
            end else if (pcnt == PCNT_LAST && timer_value != 16'd0) begin
              pcnt        <= '0;
              timer_value <= timer_value - 16'd1;
              tick        <= 1'b1;
              if (timer_value == 16'd1) begin
                expired <= 1'b1;
`ifndef TIMER_AUTORELOAD_EN
                state   <= DONE;
`endif
              end
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
          DONE: begin
            timer_value <= 16'd0;
            pcnt        <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tank_countdown_timer.sv
// Bench for tank_countdown_timer: elapsed-time model, directed windows, random enables.
// Honours TIMER_AUTORELOAD_EN the same way the design does.
module tb_tank_countdown_timer;

  localparam int CLK_FREQ_HZ = 10;
  localparam int TICK_HZ     = 1;
  localparam int PRESET      = 3;
  localparam int DIV         = CLK_FREQ_HZ / TICK_HZ;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        timer_reset = 1'b0;
  logic        timer_enable = 1'b0;
  logic [15:0] timer_value;
  logic        tick, expired, running;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  // Reference state: remaining value derived from cycles elapsed in the window.
  int m_value = PRESET;
  bit m_tick = 0, m_exp = 0, m_run = 0, m_prev_en = 0;
  int elapsed = 0;

  tank_countdown_timer #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ), .TICK_HZ(TICK_HZ), .PRESET(PRESET)
  ) dut (
    .clk(clk), .rst(rst), .timer_reset(timer_reset), .timer_enable(timer_enable),
    .timer_value(timer_value), .tick(tick), .expired(expired), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    int k, r;
    bit rise;
    m_tick = 0;
    m_exp  = 0;
    if (rst) begin
      m_value = PRESET; m_run = 0; m_prev_en = 0; elapsed = 0;
    end else begin
      rise = timer_enable && !m_prev_en;
      m_prev_en = timer_enable;
      if (timer_reset) begin
        m_value = PRESET; m_run = 0;
      end else if (rise) begin
        m_value = PRESET; m_run = 1; elapsed = 0;
      end else if (m_run && !timer_enable) begin
        m_run = 0;
      end else if (m_run) begin
        elapsed++;
        k = elapsed / DIV;
        r = elapsed % DIV;
        m_tick = (r == 0);
`ifdef TIMER_AUTORELOAD_EN
        if (r == 0 && k % PRESET == 0) begin
          m_value = 0; m_exp = 1;
        end else begin
          m_value = PRESET - (k % PRESET);
        end
`else
        m_value = PRESET - k;
        if (k == PRESET) begin
          m_exp = 1; m_run = 0;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("timer_value", 32'(timer_value), 32'(m_value));
      chk("tick", 32'(tick), 32'(m_tick));
      chk("expired", 32'(expired), 32'(m_exp));
      chk("running", 32'(running), 32'(m_run));
    end
  end

  initial begin
    // Reset for two cycles, then pin the reset values.
    step(2);
    rst = 1'b0;
    checking = 1'b1;
    chk("lit_reset_value", 32'(timer_value), 32'd3);
    chk("lit_reset_running", 32'(running), 32'd0);
    chk("lit_reset_tick_exp", 32'({tick, expired}), 32'd0);

    // Full countdown from a held enable.
    timer_enable = 1'b1;
    step(1);
    chk("lit_reload_value", 32'(timer_value), 32'd3);
    chk("lit_reload_running", 32'(running), 32'd1);
    step(10);
    chk("lit_tick1", 32'({tick, timer_value}), {15'd0, 1'b1, 16'd2});
    step(10);
    chk("lit_tick2", 32'({tick, timer_value}), {15'd0, 1'b1, 16'd1});
    step(10);
    chk("lit_expire", 32'({tick, expired, timer_value}), {14'd0, 2'b11, 16'd0});
`ifdef TIMER_AUTORELOAD_EN
    step(1);
    chk("lit_autoreload", 32'(timer_value), 32'd3);
    step(29);
    chk("lit_expire2", 32'({expired, timer_value}), {15'd0, 1'b1, 16'd0});
    step(1);
    chk("lit_autoreload2", 32'(timer_value), 32'd3);
`else
    step(29);
    chk("lit_done_hold", 32'({expired, running, timer_value}), 32'd0);
`endif

    // Stale-zero re-arm: drop enable one cycle and raise again.
    timer_enable = 1'b0;
    step(1);
    timer_enable = 1'b1;
    step(1);
    chk("lit_rearm_value", 32'(timer_value), 32'd3);
    chk("lit_rearm_running", 32'(running), 32'd1);
    step(29);
    chk("lit_rearm_29", 32'({expired, timer_value}), 32'd1);

    // Pause and reload.
    rst = 1'b1; timer_enable = 1'b0;
    step(2);
    rst = 1'b0;
    timer_enable = 1'b1;
    step(15);
    chk("lit_pause_run", 32'(timer_value), 32'd2);
    timer_enable = 1'b0;
    step(20);
    chk("lit_pause_hold", 32'({running, timer_value}), 32'd2);
    timer_enable = 1'b1;
    step(1);
    chk("lit_pause_reload", 32'({running, timer_value}), {15'd0, 1'b1, 16'd3});

    // timer_reset beats a simultaneous enable rise; no restart while enable stays high.
    timer_enable = 1'b0;
    step(1);
    timer_reset = 1'b1; timer_enable = 1'b1;
    step(1);
    chk("lit_prio_value", 32'({running, timer_value}), 32'd3);
    timer_reset = 1'b0;
    step(40);
    chk("lit_prio_idle", 32'({running, timer_value}), 32'd3);

    // Terminal tick coinciding with enable falling: pause wins, value stays 1.
    timer_enable = 1'b0;
    step(1);
    timer_enable = 1'b1;
    step(30);
    timer_enable = 1'b0;
    step(1);
    chk("lit_pause_terminal", 32'({expired, running, timer_value}), 32'd1);

    // Randomized enables, resets and timer_resets against the model.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      timer_reset = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 29) == 0) timer_enable = ~timer_enable;
      step(1);
    end
    rst = 1'b0; timer_reset = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tank_countdown_timer.md
# tank_countdown_timer

Countdown timer serving the tank control FSM's timeout windows (5 s enemy-detect window, 5 s hit-confirm window). It consumes the FSM's `timer_reset`/`timer_enable` controls and returns `timer_value`, a millisecond countdown that saturates at 0. It also emits a tick strobe and a one-cycle expiry pulse for debug LEDs and logging. One instance sits beside the FSM in the tank top level.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency.
- `TICK_HZ`, 1000, countdown rate. `DIV = CLK_FREQ_HZ / TICK_HZ` must be an integer ≥ 2.
- `PRESET`, 5000, load value in ticks. Must satisfy 1 ≤ PRESET ≤ 65535.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset: synchronous, active-high.
- `timer_reset`  in  1  level; while high, holds the counter at PRESET.
- `timer_enable`  in  1  level; while high, counts down.
- `timer_value`  out  16  remaining ticks, registered.
- `tick`  out  1  one-cycle pulse on each decrement.
- `expired`  out  1  one-cycle pulse on the cycle `timer_value` first reads 0.
- `running`  out  1  high in RUN state.

## Operation
- Internal registers:
  - prescaler `pcnt`, width `$clog2(DIV)`.
  - `enable_d`, the previous-cycle `timer_enable`.
  - state ∈ {IDLE, RUN, DONE}.
- Priority per cycle, highest first: `rst` > `timer_reset` > enable rising edge > decrement.
- `rst` or `timer_reset` high:
  - `timer_value` ← PRESET, `pcnt` ← 0, state ← IDLE.
  - `tick` = 0, `expired` = 0.
- Enable rising edge (`timer_enable` & !`enable_d`):
  - `timer_value` ← PRESET, `pcnt` ← 0, state ← RUN.
  - Guarantees a fresh window on every FSM entry into a timed state, even if a stale 0 remains from an earlier window.
- IDLE → RUN on enable rising edge.
- RUN:
  - `pcnt` increments each cycle.
  - At `pcnt == DIV-1`: `pcnt` ← 0, `timer_value` ← `timer_value` − 1, `tick` pulses.
  - If the decrement produces 0: state ← DONE, `expired` pulses coincident with `timer_value` = 0.
- RUN → IDLE if `timer_enable` falls. `timer_value` and `pcnt` freeze (pause). Re-raising enable reloads, so there is no resume.
- DONE:
  - `timer_value` holds 0, `pcnt` held at 0, no `tick`, no further `expired`.
  - Exits only via `timer_reset`, `rst`, or an enable rising edge.
- Arithmetic: unsigned 16-bit, never decrements below 0. `timer_value` is never written with an out-of-range value.
- `running` = (state == RUN).

## Timing
- Reset values:
  - `timer_value` = PRESET (never 0 out of reset, so the FSM sees no false timeout).
  - `tick` = 0, `expired` = 0, `running` = 0, state IDLE, `enable_d` = 0.
- All outputs are registered and change one cycle after the causing input edge.
- With enable rising at cycle N sampled (reload at N+1), first decrement lands at cycle N+1+DIV. Full expiry lands at N+1+PRESET·DIV.
- `expired` is high for exactly one cycle per window.
- Simultaneous events:
  - `timer_reset` with enable rising: reset wins, and `enable_d` still updates. No reload-to-RUN occurs that cycle.
  - If enable then stays high after `timer_reset` drops, the counter stays IDLE until enable falls and rises again.
- Enable falling on the same cycle as a terminal tick: the pause wins, no decrement, value stays 1.
- `rst` mid-count: immediate return to reset values on the next edge.

## Configuration
- `TIMER_AUTORELOAD_EN` defined:
  - On the cycle after `expired`, `timer_value` ← PRESET and state stays RUN.
  - `expired` pulses once every PRESET·DIV cycles while enable is held. DONE is unreachable.
- Undefined (default): behaviour as above, holding 0 in DONE.

## Test plan
Use CLK_FREQ_HZ=10, TICK_HZ=1 (DIV=10), PRESET=3.
- Reset check: assert `rst` 2 cycles → `timer_value`=3, `tick`=`expired`=`running`=0.
- Full countdown: raise `timer_enable` at cycle 0 and hold.
  - `tick` at cycles 11, 21, 31; `timer_value` 2, 1, 0.
  - `expired`=1 only at cycle 31; value stays 0 through cycle 60.
- Pause and reload: enable high for 15 cycles (value 2), then low 20 cycles → value holds 2, `running`=0. Re-raise → value reloads to 3.
- Stale-zero re-arm: after DONE, drop enable 1 cycle and re-raise → value 3 next cycle, `running`=1, no `expired` for 30 cycles.
- Priority: `timer_reset` and enable rising in the same cycle → value 3, state IDLE, no `tick` for 40 cycles while enable stays high.
- With `TIMER_AUTORELOAD_EN`: hold enable 100 cycles → `expired` at cycles 31, 61, 91; `timer_value` returns to 3 one cycle after each.
